esop_cube_sequencer: RTL and testbench

- Time-multiplexed evaluator for an 8-input single-output ESOP function y = XOR of product cubes. One shared cube-match/XOR-accumulate datapath, sequenced over a programmable cube table, one cube per cycle.
- Used as the serial, area-minimal counterpart of the flat ESOP netlists in our benchmark flow.
- Also serves as the golden-model harness for cube lists produced by our ESOP optimisation passes.

---
 rtl/esop_pkg.sv | 21 ++
 rtl/esop_cube_match.sv | 14 +
 rtl/esop_cube_sequencer.sv | 131 +++++++++++++
 tb/tb_esop_cube_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/esop_pkg.sv
// Shared types and sizes for the ESOP cube sequencer.
//   N_IN      : number of function inputs
//   MAX_CUBES : cube table depth
//   AW        : cube table address width
//   MAX_NUM   : MAX_CUBES at the width of the active-count register
//   cube_t    : one product cube (literal-present mask + literal polarity)
//   state_t   : sequencer FSM states
package esop_pkg;
    localparam int N_IN      = 8;
    localparam int MAX_CUBES = 16;
    localparam int AW        = $clog2(MAX_CUBES);

    localparam logic [AW:0] MAX_NUM = (AW+1)'(MAX_CUBES);

    typedef struct packed {
        logic [N_IN-1:0] mask;   // 1 = input appears in the cube
        logic [N_IN-1:0] pol;    // 1 = positive literal
    } cube_t;

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
endpackage

// File: rtl/esop_cube_match.sv
// Combinational cube match: hit=1 when every literal present in the cube
// agrees with the input vector. An all-zero mask is the constant-1 cube.
//   cube : cube under test
//   x    : input vector
//   hit  : cube evaluates to 1 for x
module esop_cube_match
    import esop_pkg::*;
(
    input  cube_t           cube,
    input  logic [N_IN-1:0] x,
    output logic            hit
);
    assign hit = &(~cube.mask | ~(x ^ cube.pol));
endmodule

// File: rtl/esop_cube_sequencer.sv
// Serial ESOP evaluator: y = XOR over the active cubes of cube_hit(x),
// one cube per cycle through a single shared match/accumulate datapath.
//   clk, rst_n          : clock, synchronous active-low reset
//   cfg_we/addr/mask/pol: cube table write (accepted in IDLE only)
//   cfg_num_we/cfg_num  : active cube count write (0..MAX_CUBES, IDLE only)
//   cfg_err             : one-cycle pulse after a rejected config write
//   in_valid/ready/x    : input vector handshake
//   out_valid/ready/y   : result handshake
//   busy                : evaluation or result pending
module esop_cube_sequencer
    import esop_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [N_IN-1:0] cfg_mask,
    input  logic [N_IN-1:0] cfg_pol,
    input  logic            cfg_num_we,
    input  logic [AW:0]     cfg_num,
    output logic            cfg_err,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_y,
    output logic            busy
);
    state_t          state;
    cube_t           table_q [MAX_CUBES];
    logic [AW:0]     num_q;
    logic [AW:0]     eval_num;
    logic [AW-1:0]   idx;
    logic [N_IN-1:0] x_q;
    logic            acc;

    // A table write landing on the same edge as an input handshake must not
    // leak into that evaluation: keep the overwritten entry aside and use it
    // in place of the table for this one evaluation.
    logic            ov_valid;
    logic [AW-1:0]   ov_addr;
    cube_t           ov_cube;

    cube_t cur_cube;
    logic  hit;
    logic  last;

    assign cur_cube = (ov_valid && ov_addr == idx) ? ov_cube : table_q[idx];
    assign last     = ({1'b0, idx} == eval_num - 1'b1);

    esop_cube_match u_match (
        .cube (cur_cube),
        .x    (x_q),
        .hit  (hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            for (int i = 0; i < MAX_CUBES; i++) table_q[i] <= '0;
            num_q     <= '0;
            eval_num  <= '0;
            idx       <= '0;
            x_q       <= '0;
            acc       <= 1'b0;
            ov_valid  <= 1'b0;
            ov_addr   <= '0;
            ov_cube   <= '0;
            cfg_err   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_y     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cfg_err <= 1'b0;

            // configuration port
            if (state != IDLE) begin
                if (cfg_we || cfg_num_we) cfg_err <= 1'b1;
            end else begin
                if (cfg_we) table_q[cfg_addr] <= cube_t'{mask: cfg_mask, pol: cfg_pol};
                if (cfg_num_we) begin
                    if (cfg_num > MAX_NUM) cfg_err <= 1'b1;
                    else                   num_q   <= cfg_num;
                end
            end

            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q      <= in_x;
                        acc      <= 1'b0;
                        idx      <= '0;
                        eval_num <= num_q;
                        ov_valid <= cfg_we;
                        ov_addr  <= cfg_addr;
                        ov_cube  <= table_q[cfg_addr];
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (num_q != '0) begin
                            state <= EVAL;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_y     <= 1'b0;
                        end
                    end
                end
                EVAL: begin
                    acc <= acc ^ hit;
                    idx <= idx + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_y     <= acc ^ hit;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_esop_cube_sequencer.sv
// Self-checking bench for esop_cube_sequencer. A cube-list model (arrays plus
// a loop) predicts each result; a negedge compare process checks out_y
// whenever a result is presented and that nothing is presented otherwise.
module tb_esop_cube_sequencer;
    import esop_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_we = 1'b0;
    logic [AW-1:0]   cfg_addr = '0;
    logic [N_IN-1:0] cfg_mask = '0;
    logic [N_IN-1:0] cfg_pol = '0;
    logic            cfg_num_we = 1'b0;
    logic [AW:0]     cfg_num = '0;
    logic            cfg_err;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N_IN-1:0] in_x = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_y;
    logic            busy;

    esop_cube_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_mask   (cfg_mask),
        .cfg_pol    (cfg_pol),
        .cfg_num_we (cfg_num_we),
        .cfg_num    (cfg_num),
        .cfg_err    (cfg_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model state
    logic [7:0] m_mask [16];
    logic [7:0] m_pol  [16];
    int         m_num = 0;
    bit         exp_y = 1'b0;
    bit         exp_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic bit model_eval(input logic [7:0] x);
        bit y = 1'b0;
        for (int i = 0; i < m_num; i++)
            if (((x ^ m_pol[i]) & m_mask[i]) == 8'h00) y = ~y;
        return y;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin m_mask[i] = '0; m_pol[i] = '0; end
        m_num = 0;
    endtask

    // compare process
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_pending) begin
                if (out_valid) check("cmp_out_y", out_y, exp_y);
            end else begin
                check("cmp_no_result", out_valid, 0);
            end
        end
    end

    // all tasks start and end at #1 after a rising edge
    task automatic cfg_cube(input int a, input logic [7:0] mk, input logic [7:0] pl);
        cfg_we = 1'b1; cfg_addr = a[AW-1:0]; cfg_mask = mk; cfg_pol = pl;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_mask[a] = mk; m_pol[a] = pl;
    endtask

    task automatic cfg_n(input int n);
        cfg_num_we = 1'b1; cfg_num = n[AW:0];
        @(posedge clk); #1;
        cfg_num_we = 1'b0;
        if (n <= 16) m_num = n;
    endtask

    // called just after the accept edge; waits for the result, holds it for
    // 'hold' cycles checking stability, then completes the handshake
    task automatic wait_result(input int hold, output bit y, output int lat);
        lat = 1;
        while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
        check("out_valid_arrives", out_valid, 1);
        y = out_y;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_out_y", out_y, y);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_pending = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    task automatic run(input logic [7:0] x, input int hold, output bit y, output int lat);
        check("in_ready_idle", in_ready, 1);
        exp_y = model_eval(x); exp_pending = 1'b1;
        in_valid = 1'b1; in_x = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(hold, y, lat);
        check("run_y_model", y, exp_y);
    endtask

    initial begin
        bit y;
        int lat;
        model_clear();

        // reset
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_err", cfg_err, 0);

        // single cube ~x0&~x2
        cfg_cube(0, 8'h05, 8'h00);
        cfg_n(1);
        run(8'h00, 0, y, lat);
        check("one_cube_y_x00", y, 1);
        check("one_cube_lat", lat, 2);
        run(8'h01, 0, y, lat);
        check("one_cube_y_x01", y, 0);

        // two identical cubes cancel
        cfg_cube(1, 8'h05, 8'h00);
        cfg_n(2);
        run(8'h00, 0, y, lat);
        check("cancel_y", y, 0);
        check("cancel_lat", lat, 3);

        // empty function
        cfg_n(0);
        run(8'hA5, 0, y, lat);
        check("num0_y", y, 0);
        check("num0_lat", lat, 1);

        // backpressure
        cfg_n(1);
        run(8'h00, 5, y, lat);
        check("bp_y", y, 1);

        // config write during EVAL is rejected
        cfg_n(2);
        exp_y = model_eval(8'h00); exp_pending = 1'b1;
        in_valid = 1'b1; in_x = 8'h00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = '0; cfg_mask = 8'hFF; cfg_pol = 8'hFF;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        check("err_eval_pulse", cfg_err, 1);
        @(posedge clk); #1;
        check("err_eval_pulse_end", cfg_err, 0);
        wait_result(0, y, lat);
        check("err_eval_y", y, 0);
        cfg_n(1);
        run(8'h00, 0, y, lat);
        check("err_old_cube_y", y, 1);

        // out-of-range count
        cfg_n(17);
        check("err_num17", cfg_err, 1);
        run(8'h00, 0, y, lat);
        check("num17_kept_y", y, 1);
        check("num17_kept_lat", lat, 2);

        // cube write, count write and handshake on the same edge
        exp_y = model_eval(8'h00); exp_pending = 1'b1;
        cfg_we = 1'b1; cfg_addr = '0; cfg_mask = 8'h01; cfg_pol = 8'h01;
        cfg_num_we = 1'b1; cfg_num = 5'd2;
        in_valid = 1'b1; in_x = 8'h00;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_num_we = 1'b0; in_valid = 1'b0;
        m_mask[0] = 8'h01; m_pol[0] = 8'h01; m_num = 2;
        wait_result(0, y, lat);
        check("simul_y_pre_edge", y, 1);
        check("simul_lat_pre_edge", lat, 2);
        run(8'h01, 0, y, lat);
        check("simul_after_x01", y, 1);
        run(8'h04, 0, y, lat);
        check("simul_after_x04", y, 0);

        // random table, random vectors
        for (int i = 0; i < 16; i++)
            cfg_cube(i, 8'($urandom_range(0, 255) & $urandom_range(0, 255)),
                        8'($urandom_range(0, 255)));
        cfg_n(16);
        for (int v = 0; v < 1000; v++)
            run(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)), y, lat);
        check("rand_lat", lat, 17);

        // reset in the middle of an evaluation
        exp_y = model_eval(8'h3C); exp_pending = 1'b1;
        in_valid = 1'b1; in_x = 8'h3C;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        exp_pending = 1'b0;
        model_clear();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            check("midrst_no_result", out_valid, 0);
        end
        run(8'hFF, 0, y, lat);
        check("midrst_num0_lat", lat, 1);
        check("midrst_num0_y", y, 0);
        cfg_n(1);
        run(8'h5A, 0, y, lat);
        check("midrst_table_cleared_y", y, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end
endmodule
